uart_rx_frame_capture: RTL and testbench
========================================

# uart_rx_frame_capture

UART receiver front end: synchronises the serial `rx` line, detects and validates the start bit, and oversamples each bit at mid-point. It shifts in 7 data bits (LSB first), 1 parity bit and 1 stop bit, and presents the result as a 9-bit frame register with a valid/ack handshake. It sits directly upstream of the receiver error detector (`ErrorDetectorRx`), which consumes `frame[8:0]` combinationally to flag parity and framing errors.

## Interface
- `DATA_BITS`, 7, data bits per frame; the frame width is `DATA_BITS+2`.
- `OVERSAMPLE`, 16, `sample_tick` pulses per bit period; must be even and ≥ 4.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_tick`  in  1  one-cycle enable from the baud generator at `OVERSAMPLE`× the baud rate.
- `rx`  in  1  raw asynchronous serial line; idles high.
- `frame_ack`  in  1  consumer has taken the frame; one cycle.
- `frame`  out  `DATA_BITS+2`  bit 8 is stop, bit 7 is parity, bits [6:0] are data (bit 0 is first received).
- `frame_valid`  out  1  `frame` holds an unconsumed frame.
- `overrun`  out  1  sticky flag: a frame was overwritten before it was acked.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchroniser.** `rx` passes through a 2-flop synchroniser that resets to 1. All decisions use the synchronised value `rx_s`.
- **Tick gating.** The FSM and the tick counter advance only on cycles where `sample_tick` = 1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE.**
  - If `rx_s` = 0 on a tick: clear `tick_cnt` and go to START.
- **START.**
  - On the tick where `tick_cnt` = `OVERSAMPLE/2-1` (mid start bit), sample `rx_s`.
  - If the sample is 1, it is a false start: return to IDLE.
  - If the sample is 0: clear `tick_cnt` and `bit_cnt`, then go to DATA.
- **DATA.**
  - On each tick where `tick_cnt` = `OVERSAMPLE-1`, sample `rx_s` into `shift[bit_cnt]` and clear `tick_cnt`.
  - After the sample with `bit_cnt` = `DATA_BITS-1`, go to PARITY.
- **PARITY.**
  - After `OVERSAMPLE` ticks, sample into `shift[7]` and go to STOP.
- **STOP.**
  - After `OVERSAMPLE` ticks, sample into `shift[8]` and load the whole frame into `frame`.
  - If the stop sample is 1, go to IDLE.
  - If the stop sample is 0, go to WAIT_IDLE.
- **WAIT_IDLE.**
  - Stay until `rx_s` = 1 on a tick, then go to IDLE. This prevents a break or framing error from being read as a new start bit.
- **No checking in this block.** Parity and stop values are stored as received; error detection is downstream.
- **Handshake.**
  - On frame load: `frame_valid` ← 1.
  - On `frame_ack` with no load in the same cycle: `frame_valid` ← 0 and `overrun` ← 0.
  - `frame` holds its value until the next load.
- **Overrun.**
  - A load while `frame_valid` = 1 and no `frame_ack` that cycle: the new frame overwrites the old one and `overrun` ← 1.
- **Load and ack in the same cycle.** The new frame is loaded, `frame_valid` stays 1, and `overrun` is cleared and not set.
- **Ack while `frame_valid` = 0.** Ignored.

## Timing
- **Reset values.** `frame` = 0, `frame_valid` = 0, `overrun` = 0, `busy` = 0, state = IDLE, both counters = 0, synchroniser flops = 1.
- **Input latency.** 2 `clk` cycles from `rx` to `rx_s`.
- **Frame latency.**
  - The stop sample occurs `OVERSAMPLE/2 - 1 + OVERSAMPLE*(DATA_BITS+2)` ticks after the start-detect tick; that is 151 ticks at the defaults.
  - `frame` and `frame_valid` update in the `clk` cycle after the stop-sample tick edge (registered).
- **Back-to-back frames.** A start edge can be accepted on the first tick after returning to IDLE, so no gap is needed beyond the stop bit.
- **Counter widths.**
  - `tick_cnt`: `$clog2(OVERSAMPLE)` bits.
  - `bit_cnt`: `$clog2(DATA_BITS)` bits.
  - Both are cleared on every state change; no wrap occurs inside a state.
- **Reset mid-frame.**
  - Immediate abort to IDLE; the partial frame is discarded and outputs take their reset values.
  - After release, a low line is treated as a start only on a fresh sample in IDLE.

## Structure
- **Package `uart_rx_pkg`:**
  - state enum `rx_state_t`;
  - `OVERSAMPLE_DEF` = 16;
  - `DATA_BITS_DEF` = 7;
  - `FRAME_W` = `DATA_BITS_DEF+2`;
  - bit-index constants `STOP_IDX` = 8 and `PARITY_IDX` = 7.
- **Sub-module `rx_sync2`:** 2-flop synchroniser, reset value 1, reusable elsewhere.
- **Top level:** the FSM, counters and handshake registers stay in the top module.

## Test plan
- Send data 7'h55 with parity 1 and stop 1 → `frame` = 9'h1D5, `frame_valid` rises 151 ticks + 1 cycle after start detect. Then ack → `frame_valid` = 0.
- Send 7'h41 with parity 1 and stop 0, holding the line low for 3 more bit periods → `frame` = 9'h0C1 with `frame_valid` = 1. State stays WAIT_IDLE until `rx` returns high, and no second frame appears.
- Hold `rx` low for 4 ticks, then high → no frame, `busy` returns to 0 at the mid-start tick, state = IDLE.
- Send 9'h1D5 then 9'h1AA with no ack → `overrun` = 1, `frame` = 9'h1AA. Then ack → `overrun` = 0, `frame_valid` = 0.
- Ack asserted in the same cycle as the second frame load → `frame_valid` = 1, `overrun` = 0.
- Assert `rst_n` = 0 during DATA bit 3 → all outputs at reset values. Then a full 9'h1D5 frame after release is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and default geometry for the UART receive frame capture path.
package uart_rx_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 7;
    localparam int unsigned FRAME_W        = DATA_BITS_DEF + 2;
    localparam int unsigned STOP_IDX       = 8;
    localparam int unsigned PARITY_IDX     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for an asynchronous level; resets to the idle-high value.
module rx_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame_capture.sv
// UART receive front end: start-bit validation, mid-bit oversampling and a
// valid/ack frame register with a sticky overrun flag.
module uart_rx_frame_capture
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 frame_ack,
    output logic [DATA_BITS+1:0] frame,
    output logic                 frame_valid,
    output logic                 overrun,
    output logic                 busy
);

    localparam bit          DEF_GEOM = (DATA_BITS == DATA_BITS_DEF);
    localparam int unsigned FW       = DEF_GEOM ? FRAME_W    : DATA_BITS + 2;
    localparam int unsigned STOP_I   = DEF_GEOM ? STOP_IDX   : DATA_BITS + 1;
    localparam int unsigned PAR_I    = DEF_GEOM ? PARITY_IDX : DATA_BITS;
    localparam int unsigned TICK_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS);
    localparam int unsigned IDX_W    = $clog2(FW);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic              rx_s;
    rx_state_t         state, state_n;
    logic [TICK_W-1:0] tick_cnt, tick_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [FW-1:0]     shift, shift_n;
    logic              load_pend, load_n;

    rx_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The detect tick is the first tick of the start bit, so the counter
    // leaves IDLE already at 1 and the mid-start sample lands 7 ticks later.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        load_n  = 1'b0;
        if (sample_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        tick_n  = TICK_W'(1);
                        bit_n   = '0;
                        state_n = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n                    = '0;
                        shift_n[IDX_W'(bit_cnt)] = rx_s;
                        if (bit_cnt == BIT_LAST) begin
                            bit_n   = '0;
                            state_n = ST_PARITY;
                        end else begin
                            bit_n = bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n         = '0;
                        shift_n[PAR_I] = rx_s;
                        state_n        = ST_STOP;
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n          = '0;
                        shift_n[STOP_I] = rx_s;
                        load_n          = 1'b1;
                        state_n         = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        tick_n  = '0;
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            load_pend <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            load_pend <= load_n;
            busy      <= (state_n != ST_IDLE);
        end
    end

    // An ack landing with a load keeps the new frame valid and clears overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (load_pend) begin
            frame       <= shift;
            frame_valid <= 1'b1;
            if (frame_ack) begin
                overrun <= 1'b0;
            end else if (frame_valid) begin
                overrun <= 1'b1;
            end
        end else if (frame_ack && frame_valid) begin
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_capture.sv
// Directed bench for uart_rx_frame_capture with a tick-offset reference model.
module tb_uart_rx_frame_capture;
    import uart_rx_pkg::*;

    localparam int OS     = OVERSAMPLE_DEF;
    localparam int HALF   = OVERSAMPLE_DEF / 2 - 1;
    localparam int NBITS  = FRAME_W;
    localparam int LAST_N = HALF + OS * NBITS;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample_tick;
    logic               rx;
    logic               frame_ack;
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               overrun;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int tcount = 0;
    int t_fall = 0;
    int t_rise = 0;
    logic prev_v = 1'b0;

    uart_rx_frame_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx),
        .frame_ack   (frame_ack),
        .frame       (frame),
        .frame_valid (frame_valid),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Tick every 4th clock
    initial begin
        int div;
        div = 0;
        sample_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            sample_tick = (div == 0);
        end
    end

    always @(posedge clk) if (sample_tick) tcount++;

    always @(negedge clk) begin
        if (frame_valid && !prev_v) t_rise = tcount;
        prev_v = frame_valid;
    end

    // Reference model: bit k of a frame is the synchronised line value
    // HALF + OS*(k+1) ticks after the start-detect tick.
    logic               m_d1, m_d2, rxs;
    int                 m_mode, m_t0, tk, n, k;
    logic [FRAME_W-1:0] m_bits, m_newf;
    logic               m_pend;
    logic [FRAME_W-1:0] exp_frame;
    logic               exp_valid, exp_ovr, exp_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = 1'b1; m_d2 = 1'b1; m_mode = 0; m_t0 = 0; tk = 0;
            m_bits = '0; m_newf = '0; m_pend = 1'b0;
            exp_frame = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_busy = 1'b0;
        end else begin
            rxs = m_d2;
            if (m_pend) begin
                if (frame_ack) exp_ovr = 1'b0;
                else if (exp_valid) exp_ovr = 1'b1;
                exp_frame = m_newf;
                exp_valid = 1'b1;
            end else if (frame_ack && exp_valid) begin
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
            end
            m_pend = 1'b0;
            if (sample_tick) begin
                tk++;
                if (m_mode == 0) begin
                    if (!rxs) begin m_mode = 1; m_t0 = tk; end
                end else if (m_mode == 1) begin
                    n = tk - m_t0;
                    if (n == HALF && rxs) begin
                        m_mode = 0;
                    end else if (n > HALF && (n - HALF) % OS == 0) begin
                        k = (n - HALF) / OS - 1;
                        m_bits[k] = rxs;
                        if (n == LAST_N) begin
                            m_newf = m_bits;
                            m_pend = 1'b1;
                            m_mode = rxs ? 0 : 2;
                        end
                    end
                end else begin
                    if (rxs) m_mode = 0;
                end
            end
            exp_busy = (m_mode != 0);
            m_d2 = m_d1;
            m_d1 = rx;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("frame", 32'(frame), 32'(exp_frame));
            check("frame_valid", 32'(frame_valid), 32'(exp_valid));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            check("busy", 32'(busy), 32'(exp_busy));
        end
    end

    task automatic wait_ticks(input int cnt);
        int c;
        c = 0;
        while (c < cnt) begin
            @(posedge clk);
            if (sample_tick) c++;
        end
        #1;
    endtask

    task automatic line_idle(input int cnt);
        rx = 1'b1;
        wait_ticks(cnt);
    endtask

    task automatic send_frame(input logic [FRAME_W-1:0] f);
        t_fall = tcount;
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < NBITS; i++) begin
            rx = f[i];
            wait_ticks(OS);
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 frame_ack = 1'b1;
        @(posedge clk);
        #1 frame_ack = 1'b0;
    endtask

    task automatic ack_on_load();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_pend) begin
                frame_ack = 1'b1;
                @(posedge clk);
                #1 frame_ack = 1'b0;
                found = 1'b1;
            end
        end
        check("load_seen", 32'(found), 32'd1);
    endtask

    logic [FRAME_W-1:0] f;

    initial begin
        rx = 1'b1;
        frame_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        line_idle(5);

        // 7'h55, parity 1, stop 1
        send_frame(9'h1D5);
        line_idle(4);
        @(negedge clk);
        check("t1_frame", 32'(frame), 32'h1D5);
        check("t1_valid", 32'(frame_valid), 32'h1);
        check("t1_latency", 32'(t_rise - t_fall), 32'd152);
        ack_pulse();
        @(negedge clk);
        check("t1_ack_valid", 32'(frame_valid), 32'h0);

        // 7'h41, parity 1, stop 0, then a held break
        line_idle(3);
        send_frame(9'h0C1);
        wait_ticks(3 * OS);
        @(negedge clk);
        check("t2_frame", 32'(frame), 32'h0C1);
        check("t2_parity", 32'(frame[PARITY_IDX]), 32'h1);
        check("t2_stop", 32'(frame[STOP_IDX]), 32'h0);
        check("t2_busy_wait", 32'(busy), 32'h1);
        line_idle(8);
        @(negedge clk);
        check("t2_busy_idle", 32'(busy), 32'h0);
        check("t2_frame_kept", 32'(frame), 32'h0C1);
        check("t2_no_overrun", 32'(overrun), 32'h0);
        ack_pulse();

        // False start: 4 ticks low
        line_idle(3);
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(2);
        @(negedge clk);
        check("t3_busy_pre_mid", 32'(busy), 32'h1);
        wait_ticks(4);
        @(negedge clk);
        check("t3_busy_post_mid", 32'(busy), 32'h0);
        check("t3_no_frame", 32'(frame_valid), 32'h0);

        // Overrun with no ack
        line_idle(3);
        send_frame(9'h1D5);
        send_frame(9'h1AA);
        line_idle(4);
        @(negedge clk);
        check("t4_overrun", 32'(overrun), 32'h1);
        check("t4_frame", 32'(frame), 32'h1AA);
        ack_pulse();
        @(negedge clk);
        check("t4_ack_overrun", 32'(overrun), 32'h0);
        check("t4_ack_valid", 32'(frame_valid), 32'h0);

        // Ack coinciding with the second load
        line_idle(3);
        send_frame(9'h1D5);
        fork
            send_frame(9'h1AA);
            ack_on_load();
        join
        line_idle(4);
        @(negedge clk);
        check("t5_valid", 32'(frame_valid), 32'h1);
        check("t5_overrun", 32'(overrun), 32'h0);
        check("t5_frame", 32'(frame), 32'h1AA);
        ack_pulse();

        // Reset during data bit 3
        line_idle(3);
        f = 9'h1D5;
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            rx = f[i];
            wait_ticks(OS);
        end
        rx = f[3];
        wait_ticks(OS / 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_frame", 32'(frame), 32'h0);
        check("t6_rst_valid", 32'(frame_valid), 32'h0);
        check("t6_rst_overrun", 32'(overrun), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        line_idle(4);
        send_frame(9'h1D5);
        line_idle(4);
        @(negedge clk);
        check("t6_frame", 32'(frame), 32'h1D5);
        check("t6_valid", 32'(frame_valid), 32'h1);
        check("t6_latency", 32'(t_rise - t_fall), 32'd152);
        ack_pulse();
        line_idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
